// File: rtl/ex_mem_pkg.sv
// rtl/ex_mem_pkg.sv - shared widths, skid-buffer state encoding and payload sizing for ex_mem
package ex_mem_pkg;

    localparam int EXM_XLEN   = 32;
    localparam int EXM_PC_W   = 32;
    localparam int EXM_MASK_W = 8;
    localparam int EXM_RS_W   = 5;

    // wenReg, wenCsr, wenMem, renMem, is_load_signed
    localparam int EXM_CTRL_W = 5;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    function automatic int exm_payload_w(input int xlen, input int pc_w, input int mask_w, input int rs_w);
        return 3 * xlen + pc_w + mask_w + rs_w + EXM_CTRL_W;
    endfunction

endpackage

// File: rtl/ex_mem_pipe_skid_buf.sv
// rtl/ex_mem_pipe_skid_buf.sv - generic two-entry skid buffer (main + skid) with registered ready and flush
module ex_mem_pipe_skid_buf
    import ex_mem_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [WIDTH-1:0] m_tdata
);

    buf_state_e       state_q;
    buf_state_e       state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             load_main;
    logic             load_skid;
    logic             main_from_skid;
    logic             xfer_in;
    logic             xfer_out;

    // Ready depends only on the state register, so there is no LSU->EXU combinational path.
    assign s_tready = (state_q != BUF_FULL);
    assign m_tvalid = (state_q != BUF_EMPTY);
    assign m_tdata  = main_q;
    assign xfer_in  = s_tvalid & s_tready;
    assign xfer_out = m_tvalid & m_tready;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= BUF_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q <= main_from_skid ? skid_q : s_tdata;
            end
            if (load_skid) begin
                skid_q <= s_tdata;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            BUF_EMPTY: begin
                if (xfer_in) begin
                    load_main = 1'b1;
                    state_d   = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (xfer_in && xfer_out) begin
                    load_main = 1'b1;
                end else if (xfer_in) begin
                    load_skid = 1'b1;
                    state_d   = BUF_FULL;
                end else if (xfer_out) begin
                    state_d   = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                // The skid entry is always older than anything still upstream.
                if (xfer_out) begin
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = BUF_ONE;
                end
            end
            default: begin
                state_d = BUF_EMPTY;
            end
        endcase
        if (flush) begin
            state_d   = BUF_EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
        end
    end

endmodule

// File: rtl/ex_mem.sv
// rtl/ex_mem.sv - EX->MEM pipeline register on a skid buffer; forwarding under YSYX_23060251_EXMEM_FWD_EN
module ex_mem
    import ex_mem_pkg::*;
#(
    parameter int XLEN   = EXM_XLEN,
    parameter int PC_W   = EXM_PC_W,
    parameter int MASK_W = EXM_MASK_W,
    parameter int RS_W   = EXM_RS_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              e_valid_i,
    output logic              E_ready_o,
    input  logic [XLEN-1:0]   e_alu_result_i,
    input  logic [XLEN-1:0]   e_src2_i,
    input  logic [RS_W-1:0]   e_rd_i,
    input  logic              e_wenReg_i,
    input  logic              e_wenCsr_i,
    input  logic [XLEN-1:0]   e_csr_data_i,
    input  logic              e_wenMem_i,
    input  logic              e_renMem_i,
    input  logic              e_is_load_signed_i,
    input  logic [MASK_W-1:0] e_mask_i,
    input  logic [PC_W-1:0]   e_pc_i,
    input  logic              flush_i,
    output logic [XLEN-1:0]   m_alu_result_o,
    output logic [XLEN-1:0]   m_src2_o,
    output logic [RS_W-1:0]   m_rd_o,
    output logic              m_wenReg_o,
    output logic              m_wenCsr_o,
    output logic [XLEN-1:0]   m_csr_data_o,
    output logic              m_wenMem_o,
    output logic              m_renMem_o,
    output logic              m_is_load_signed_o,
    output logic [MASK_W-1:0] m_mask_o,
    output logic [PC_W-1:0]   m_pc_o,
    output logic              M_valid_o,
    input  logic              m_ready_i,
    output logic              fwd_valid_o,
    output logic [RS_W-1:0]   fwd_rd_o,
    output logic [XLEN-1:0]   fwd_data_o
);

    localparam int PAY_W = exm_payload_w(XLEN, PC_W, MASK_W, RS_W);

    logic [PAY_W-1:0] in_pay;
    logic [PAY_W-1:0] out_pay;

    assign in_pay = {e_alu_result_i, e_src2_i, e_csr_data_i, e_pc_i, e_mask_i, e_rd_i,
                     e_wenReg_i, e_wenCsr_i, e_wenMem_i, e_renMem_i, e_is_load_signed_i};

    assign {m_alu_result_o, m_src2_o, m_csr_data_o, m_pc_o, m_mask_o, m_rd_o,
            m_wenReg_o, m_wenCsr_o, m_wenMem_o, m_renMem_o, m_is_load_signed_o} = out_pay;

    ex_mem_pipe_skid_buf #(
        .WIDTH(PAY_W)
    ) u_skid (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .flush    (flush_i),
        .s_tvalid (e_valid_i),
        .s_tready (E_ready_o),
        .s_tdata  (in_pay),
        .m_tvalid (M_valid_o),
        .m_tready (m_ready_i),
        .m_tdata  (out_pay)
    );

`ifdef YSYX_23060251_EXMEM_FWD_EN
    // Load data is not known yet at this stage, so loads never forward.
    assign fwd_valid_o = M_valid_o & m_wenReg_o & (m_rd_o != '0) & ~m_renMem_o;
    assign fwd_rd_o    = m_rd_o;
    assign fwd_data_o  = m_alu_result_o;
`else
    assign fwd_valid_o = 1'b0;
    assign fwd_rd_o    = '0;
    assign fwd_data_o  = '0;
`endif

    illegal_mem_op: assert property (@(posedge clk_i) disable iff (!rst_i)
        e_valid_i |-> !(e_wenMem_i && e_renMem_i));

endmodule
